// File: rtl/out_port_uart_tx.sv
// out_port_uart_tx: queue each change of OUT and send it on TXD as an 8N1 frame, LSB first; `UART_TX_PARITY_EN adds even parity.
// Latency: push one edge after OUT changes, start bit one edge later; frame is 10 (11 with parity) bit times.
// Backpressure: none to the CPU; a change that finds the FIFO full is dropped and sets sticky OVERFLOW.
module out_port_uart_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                            CLOCK,
    input  logic                            RESET,
    input  logic [7:0]                      OUT,
    output logic                            TXD,
    output logic                            BUSY,
    output logic                            OVERFLOW,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] COUNT
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [7:0]      last_out;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [TW-1:0]   tick_cnt;
    logic [2:0]      bit_cnt;
    logic [2:0]      data_idx;
    logic [7:0]      shreg;
    logic            txd_next;
    logic            pop;

    wire push_req   = (OUT != last_out);
    wire fifo_full  = (COUNT == FULL_CNT);
    wire fifo_empty = (COUNT == '0);
    wire push       = push_req && !fifo_full;
    wire tick       = (tick_cnt == LAST_TICK);

    // Change detector and FIFO bookkeeping; full is judged on the pre-edge count, so a same-edge pop never rescues a push.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            last_out <= 8'h00;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            COUNT    <= '0;
            OVERFLOW <= 1'b0;
        end else begin
            last_out <= OUT;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_req && fifo_full)
                OVERFLOW <= 1'b1;
            case ({push, pop})
                2'b10:   COUNT <= COUNT + 1'b1;
                2'b01:   COUNT <= COUNT - 1'b1;
                default: COUNT <= COUNT;
            endcase
        end
    end

    always_ff @(posedge CLOCK) begin
        if (push)
            mem[wr_ptr] <= OUT;
    end

    // State register plus frame datapath.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= 3'd0;
            shreg    <= 8'h00;
            TXD      <= 1'b1;
        end else begin
            state    <= state_next;
            TXD      <= txd_next;
            tick_cnt <= (state == IDLE || tick) ? '0 : tick_cnt + 1'b1;
            if (pop) begin
                shreg   <= mem[rd_ptr];
                bit_cnt <= 3'd0;
            end else if (state == DATA && tick) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = START;
                    pop        = 1'b1;
                end
            end
            START: begin
                if (tick)
                    state_next = DATA;
            end
            DATA: begin
                if (tick && bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick)
                    state_next = STOP;
            end
`endif
            STOP: begin
                if (tick) begin
                    if (!fifo_empty) begin
                        state_next = START;
                        pop        = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // TXD is registered, so its next value follows the state and bit being entered.
    always_comb begin
        data_idx = (state == DATA && tick) ? bit_cnt + 3'd1 : bit_cnt;
        txd_next = 1'b1;
        case (state_next)
            START:   txd_next = 1'b0;
            DATA:    txd_next = shreg[data_idx];
`ifdef UART_TX_PARITY_EN
            PARITY:  txd_next = ^shreg;
`endif
            default: txd_next = 1'b1;
        endcase
        BUSY = (state != IDLE);
    end

endmodule
